// File: rtl/device_shift_register_if.sv
// Mode/data/result bundle for device_shift_register.
// master drives PE and D; slave returns the registered Q.
interface device_shift_register_if #(parameter int WIDTH = 4);
  logic [1:0]       PE;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;

  modport master (output PE, output D, input Q);
  modport slave  (input PE, input D, output Q);
endinterface

// File: rtl/device_shift_register.sv
// WIDTH-bit universal register: hold / shift right / shift left / load, selected by PE.
// Optional macro DEVICE_ROTATE_EN turns both shifts into rotates.
module device_shift_register_cell (
  input  logic       clk,
  input  logic       r,
  input  logic [1:0] pe_i,
  input  logic       d_i,
  input  logic       shr_i,
  input  logic       shl_i,
  output logic       q_o
);
  logic q_d, q_q;

  // Any non-decodable PE value falls back to hold.
  always_comb begin
    q_d = q_q;
    case (pe_i)
      2'b00:   q_d = q_q;
      2'b01:   q_d = shr_i;
      2'b10:   q_d = shl_i;
      2'b11:   q_d = d_i;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) q_q <= 1'b0;
    else    q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

module device_shift_register #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  r,
  device_shift_register_if.slave bus
);
  logic [WIDTH-1:0] q;
  logic             fill_r, fill_l;

`ifdef DEVICE_ROTATE_EN
  assign fill_r = q[0];
  assign fill_l = q[WIDTH-1];
`else
  assign fill_r = bus.D[WIDTH-1];
  assign fill_l = bus.D[0];
`endif

  // Each bit picks from its upper neighbour (shift right) or lower neighbour (shift left);
  // the end bits take the fill bits instead.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic shr, shl;
    if (i == WIDTH-1) begin : g_msb
      assign shr = fill_r;
    end else begin : g_nmsb
      assign shr = q[i+1];
    end
    if (i == 0) begin : g_lsb
      assign shl = fill_l;
    end else begin : g_nlsb
      assign shl = q[i-1];
    end

    device_shift_register_cell u_cell (
      .clk   (clk),
      .r     (r),
      .pe_i  (bus.PE),
      .d_i   (bus.D[i]),
      .shr_i (shr),
      .shl_i (shl),
      .q_o   (q[i])
    );
  end

  assign bus.Q = q;
endmodule

// File: tb/tb_device_shift_register.sv
// Bench for device_shift_register: directed plan checks plus random and free-running
// stimulus compared against an arithmetic reference model at every falling clock edge.
module tb_device_shift_register;
  localparam int W = 4;

  logic clk;
  logic r;
  int   n_vec = 0;
  int   n_err = 0;
  logic ck_en = 1'b0;
  logic [W-1:0] m = '0;

  device_shift_register_if #(.WIDTH(W)) bus ();

  device_shift_register #(.WIDTH(W)) dut (
    .clk (clk),
    .r   (r),
    .bus (bus)
  );

  // Period 100; edges sit on times ending in 5 so integer-aligned stimulus never races them.
  initial begin
    clk = 1'b0;
    #5;
    forever begin
      clk = 1'b1; #50;
      clk = 1'b0; #50;
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_next(input logic [W-1:0] q, input logic [1:0] pe,
                                            input logic [W-1:0] d);
    int unsigned qi, di, msk, fr, fl;
    qi  = q;
    di  = d;
    msk = (1 << W) - 1;
`ifdef DEVICE_ROTATE_EN
    fr = qi & 1;
    fl = (qi >> (W-1)) & 1;
`else
    fr = (di >> (W-1)) & 1;
    fl = di & 1;
`endif
    case (pe)
      2'd0:    return q;
      2'd1:    return W'((qi >> 1) | (fr << (W-1)));
      2'd2:    return W'(((qi << 1) & msk) | fl);
      default: return d;
    endcase
  endfunction

  always @(posedge clk or negedge r) begin
    if (!r) m <= '0;
    else    m <= ref_next(m, bus.PE, bus.D);
  end

  always @(negedge clk) begin
    if (ck_en) chk("model", bus.Q, m);
  end

  task automatic apply(input logic [1:0] pe, input logic [W-1:0] d);
    @(negedge clk);
    bus.PE = pe;
    bus.D  = d;
    @(posedge clk);
    #1;
  endtask

`ifdef DEVICE_ROTATE_EN
  localparam logic [W-1:0] EXP_SR_FILL = 4'hC;
  localparam logic [W-1:0] EXP_SL_FILL = 4'h3;
`else
  localparam logic [W-1:0] EXP_SR_FILL = 4'h4;
  localparam logic [W-1:0] EXP_SL_FILL = 4'h2;
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] dd;
    r      = 1'b0;
    bus.PE = 2'b00;
    bus.D  = '0;
    #1;
    ck_en = 1'b1;
    chk("rst_init", bus.Q, 4'h0);
    repeat (2) @(negedge clk);
    #20 r = 1'b1;

    // load then hold with D toggling
    apply(2'b11, 4'h9); chk("load", bus.Q, 4'h9);
    dd = 4'h5;
    for (int k = 0; k < 3; k++) begin
      dd = ~dd;
      apply(2'b00, dd); chk("hold", bus.Q, 4'h9);
    end

    // asynchronous reset mid-cycle, held across an edge, then first update after release
    apply(2'b11, 4'hA); chk("load_a", bus.Q, 4'hA);
    @(negedge clk);
    bus.PE = 2'b11; bus.D = 4'hF;
    #20 r = 1'b0;
    #1 chk("rst_async", bus.Q, 4'h0);
    @(posedge clk); #1 chk("rst_edge", bus.Q, 4'h0);
    @(negedge clk); #20 r = 1'b1;
    #1 chk("rst_rel", bus.Q, 4'h0);
    @(posedge clk); #1 chk("rst_first", bus.Q, 4'hF);

    // shifts from the plan (same values in both builds)
    apply(2'b11, 4'h9);
    apply(2'b01, 4'h8); chk("shr1", bus.Q, 4'hC);
    apply(2'b01, 4'h0); chk("shr2", bus.Q, 4'h6);
    apply(2'b11, 4'h9);
    apply(2'b10, 4'h1); chk("shl1", bus.Q, 4'h3);
    apply(2'b10, 4'h0); chk("shl2", bus.Q, 4'h6);
    // fill source differs between fill and rotate builds
    apply(2'b11, 4'h9);
    apply(2'b01, 4'h0); chk("shr_fill", bus.Q, EXP_SR_FILL);
    apply(2'b11, 4'h9);
    apply(2'b10, 4'h0); chk("shl_fill", bus.Q, EXP_SL_FILL);

    // random modes and data with occasional mid-cycle reset pulses
    repeat (300) begin
      @(negedge clk);
      bus.PE = 2'($urandom_range(0, 3));
      bus.D  = W'($urandom);
      if ($urandom_range(0, 24) == 0) begin
        #20 r = 1'b0;
        #1 chk("rst_rand", bus.Q, 4'h0);
        #10 r = 1'b1;
      end
    end

    // free-run: D steps every 110, PE every 1740, reset pulses at +70 and +3630
    @(negedge clk);
    #5;
    bus.PE = 2'b00;
    bus.D  = '0;
    fork
      repeat (80) begin #110; bus.D = bus.D + 1'b1; end
      repeat (5)  begin #1740; bus.PE = bus.PE + 1'b1; end
      begin
        #70 r = 1'b0;
        #10 chk("fr_rst1a", bus.Q, 4'h0);
        #20 chk("fr_rst1b", bus.Q, 4'h0);
        r = 1'b1;
        #3530 r = 1'b0;
        #10 chk("fr_rst2a", bus.Q, 4'h0);
        #20 chk("fr_rst2b", bus.Q, 4'h0);
        r = 1'b1;
      end
    join

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
